// File: rtl/lut_client_arbiter_pkg.sv
// Shared definitions for the LUT lookup initiator.
//   LUT_HANDLE_WIDTH  width of a LUT handle on the client and master sides
//   LUT_HANDLE_*      well-known table handles
//   arb_state_e       arbiter FSM state encoding
package lut_client_arbiter_pkg;

  localparam int LUT_HANDLE_WIDTH = 3;

  localparam logic [LUT_HANDLE_WIDTH-1:0] LUT_HANDLE_SIN  = LUT_HANDLE_WIDTH'(0);
  localparam logic [LUT_HANDLE_WIDTH-1:0] LUT_HANDLE_TANH = LUT_HANDLE_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RESPOND = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin priority selector.
// Searches req upward from ptr (wrapping) and returns the first requester.
//   req      in  N   request vector
//   ptr      in  IW  index where the search starts (highest priority)
//   grant    out N   one-hot grant (all zero when nothing requests)
//   idx      out IW  index of the granted requester
//   any_req  out 1   at least one request is present
module rr_priority_select #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any_req
);

  int c;

  always_comb begin
    grant   = '0;
    idx     = '0;
    any_req = 1'b0;
    c       = 0;
    for (int i = 0; i < N; i++) begin
      c = int'(ptr) + i;
      if (c >= N) c = c - N;
      if (!any_req && req[c]) begin
        any_req  = 1'b1;
        grant[c] = 1'b1;
        idx      = IW'(c);
      end
    end
  end

endmodule

// File: rtl/lut_client_arbiter.sv
// Initiator side of the LUT lookup interface. Serialises lookups from
// N_CLIENTS cores onto one LUT master port (round-robin), routes results
// back, rejects bad handles locally and times out a hung master.
//   clk, reset            clock, async active-low reset
//   client_req/handle/arg per-client level request with packed handle/arg
//   client_valid/error    one-cycle per-client done pulses
//   client_data           shared result bus (holds between pulses)
//   lut_req/handle/arg    request strobe and payload to the LUT master
//   lut_data/lut_valid    result from the LUT master
//   lut_fault             sticky master-timeout flag
module lut_client_arbiter
  import lut_client_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int N_CLIENTS      = 4,
  parameter int N_LUTS         = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [N_CLIENTS-1:0]                  client_req,
  input  logic [N_CLIENTS*LUT_HANDLE_WIDTH-1:0] client_handle,
  input  logic [N_CLIENTS*DATA_WIDTH-1:0]       client_arg,
  output logic [N_CLIENTS-1:0]                  client_valid,
  output logic [N_CLIENTS-1:0]                  client_error,
  output logic [DATA_WIDTH-1:0]                 client_data,
  output logic                                  lut_req,
  output logic [LUT_HANDLE_WIDTH-1:0]           lut_handle,
  output logic [DATA_WIDTH-1:0]                 lut_arg,
  input  logic [DATA_WIDTH-1:0]                 lut_data,
  input  logic                                  lut_valid,
  output logic                                  lut_fault
);

  localparam int HW = LUT_HANDLE_WIDTH;
  localparam int IW = $clog2(N_CLIENTS);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_e            state;
  logic [IW-1:0]         ptr;
  logic [IW-1:0]         gnt_idx;
  logic [N_CLIENTS-1:0]  gnt_oh;
  logic [HW-1:0]         lat_handle;
  logic [DATA_WIDTH-1:0] lat_arg;
  logic [CW-1:0]         cnt;

  logic [N_CLIENTS-1:0]  sel_grant;
  logic [IW-1:0]         sel_idx;
  logic                  any_req;
  logic [HW-1:0]         sel_handle;
  logic [DATA_WIDTH-1:0] sel_arg;
  logic                  sel_bad;
  logic [IW-1:0]         sel_next;
  logic [IW-1:0]         gnt_next;

  rr_priority_select #(.N(N_CLIENTS), .IW(IW)) u_sel (
    .req     (client_req),
    .ptr     (ptr),
    .grant   (sel_grant),
    .idx     (sel_idx),
    .any_req (any_req)
  );

  always_comb begin
    sel_handle = client_handle[int'(sel_idx)*HW +: HW];
    sel_arg    = client_arg[int'(sel_idx)*DATA_WIDTH +: DATA_WIDTH];
    sel_bad    = int'(sel_handle) >= N_LUTS;
    sel_next   = (sel_idx == IW'(N_CLIENTS-1)) ? '0 : sel_idx + IW'(1);
    gnt_next   = (gnt_idx == IW'(N_CLIENTS-1)) ? '0 : gnt_idx + IW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      ptr          <= '0;
      gnt_idx      <= '0;
      gnt_oh       <= '0;
      lat_handle   <= '0;
      lat_arg      <= '0;
      cnt          <= '0;
      lut_req      <= 1'b0;
      lut_handle   <= '0;
      lut_arg      <= '0;
      client_valid <= '0;
      client_error <= '0;
      client_data  <= '0;
      lut_fault    <= 1'b0;
    end else begin
      lut_req      <= 1'b0;
      client_valid <= '0;
      client_error <= '0;
      case (state)
        ST_IDLE: begin
          // While an error pulse is out, the rejected client still shows
          // client_req (it drops it only after seeing the pulse); skip one
          // arbitration so it is not granted again.
          if (any_req && client_error == '0) begin
            gnt_idx    <= sel_idx;
            gnt_oh     <= sel_grant;
            lat_handle <= sel_handle;
            lat_arg    <= sel_arg;
            if (sel_bad || lut_fault) begin
              client_error <= sel_grant;
              ptr          <= sel_next;
            end else begin
              state <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          lut_req    <= 1'b1;
          lut_handle <= lat_handle;
          lut_arg    <= lat_arg;
          cnt        <= '0;
          state      <= ST_WAIT;
        end
        ST_WAIT: begin
          // A result arriving in the timeout cycle still counts.
          if (lut_valid) begin
            client_data  <= lut_data;
            client_valid <= gnt_oh;
            state        <= ST_RESPOND;
          end else if (cnt == CW'(TIMEOUT_CYCLES-1)) begin
            lut_fault    <= 1'b1;
            client_error <= gnt_oh;
            ptr          <= gnt_next;
            state        <= ST_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_RESPOND: begin
          ptr   <= gnt_next;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lut_client_arbiter.sv
module tb_lut_client_arbiter;
  import lut_client_arbiter_pkg::*;

  localparam int DW = 16;
  localparam int NC = 4;
  localparam int NL = 2;
  localparam int TO = 16;
  localparam int HW = LUT_HANDLE_WIDTH;

  logic              clk = 1'b0;
  logic              reset;
  logic [NC-1:0]     client_req;
  logic [NC*HW-1:0]  client_handle;
  logic [NC*DW-1:0]  client_arg;
  logic [NC-1:0]     client_valid;
  logic [NC-1:0]     client_error;
  logic [DW-1:0]     client_data;
  logic              lut_req;
  logic [HW-1:0]     lut_handle;
  logic [DW-1:0]     lut_arg;
  logic [DW-1:0]     lut_data;
  logic              lut_valid;
  logic              lut_fault;

  lut_client_arbiter #(.DATA_WIDTH(DW), .N_CLIENTS(NC), .N_LUTS(NL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .client_req(client_req), .client_handle(client_handle), .client_arg(client_arg),
    .client_valid(client_valid), .client_error(client_error), .client_data(client_data),
    .lut_req(lut_req), .lut_handle(lut_handle), .lut_arg(lut_arg),
    .lut_data(lut_data), .lut_valid(lut_valid), .lut_fault(lut_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           idx;
    bit           err;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   req_count = 0;
  int   last_req_cyc = 0;
  int   last_pulse_cyc = 0;
  int   gap_viol = 0;
  logic [NC-1:0] done_mask;

  // Master model: answers lut_req after m_delay cycles unless hung.
  bit   m_hang = 1'b0;
  int   m_delay = 5;
  int   m_cnt = 0;
  logic [HW-1:0] m_h;
  logic [DW-1:0] m_a;
  int   last_valid_cyc = -100;

  function automatic logic [DW-1:0] lut_model(input logic [HW-1:0] h, input logic [DW-1:0] a);
    return a + 16'h3FFF + DW'(h) * 16'h0101;
  endfunction

  always @(negedge clk) begin
    lut_valid = 1'b0;
    if (!reset) begin
      m_cnt = 0;
      lut_data = '0;
    end else if (lut_req) begin
      if (!m_hang) begin
        m_cnt = m_delay;
        m_h = lut_handle;
        m_a = lut_arg;
      end
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        lut_valid = 1'b1;
        lut_data = lut_model(m_h, m_a);
        last_valid_cyc = cyc;
      end
    end
  end

  // One clock: sample after the edge, score any client pulse, let the
  // finished client drop its request.
  task automatic tick();
    int   g;
    bit   e;
    exp_t ex;
    @(posedge clk);
    #1;
    cyc++;
    done_mask = '0;
    if (lut_req) begin
      req_count++;
      last_req_cyc = cyc;
      if (cyc - last_valid_cyc < 3) gap_viol++;
    end
    if ((client_valid | client_error) != '0) begin
      n_vec++;
      g = 0;
      for (int i = 0; i < NC; i++) if (client_valid[i] || client_error[i]) g = i;
      e = |client_error;
      if ($countones({client_valid, client_error}) != 1) begin
        n_bad++;
        $display("FAIL pulse_onehot: valid=%b error=%b, required exactly one bit", client_valid, client_error);
      end else if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_pulse: client %0d err=%0b at cycle %0d, required none", g, e, cyc);
      end else begin
        ex = sb.pop_front();
        if (g !== ex.idx || e !== ex.err || (!e && client_data !== ex.data)) begin
          n_bad++;
          $display("FAIL scoreboard: got client %0d err=%0b data=%h, required client %0d err=%0b data=%h",
                   g, e, client_data, ex.idx, ex.err, ex.data);
        end
      end
      last_pulse_cyc = cyc;
      done_mask = client_valid | client_error;
      client_req = client_req & ~done_mask;
    end
  endtask

  task automatic push(input int idx, input bit err, input logic [DW-1:0] data);
    exp_t ex;
    ex.idx = idx; ex.err = err; ex.data = data;
    sb.push_back(ex);
  endtask

  task automatic set_client(input int i, input logic [HW-1:0] h, input logic [DW-1:0] a);
    client_handle[i*HW +: HW] = h;
    client_arg[i*DW +: DW] = a;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while ((sb.size() != 0 || client_req != '0) && n < budget) begin
      tick();
      n++;
    end
    n_vec++;
    if (sb.size() != 0 || client_req != '0) begin
      n_bad++;
      $display("FAIL %s_drain: %0d results pending after %0d cycles, required 0", tag, sb.size(), budget);
      sb.delete();
      client_req = '0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    client_req = '0;
    sb.delete();
    tick(); tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    client_req = '0;
    client_handle = '0;
    client_arg = '0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({client_valid, client_error, client_data, lut_req, lut_handle, lut_arg, lut_fault} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: valid=%b err=%b data=%h req=%b h=%h arg=%h fault=%b, required all 0",
               client_valid, client_error, client_data, lut_req, lut_handle, lut_arg, lut_fault);
    end
    reset = 1'b1;
    repeat (3) tick();
    n_vec++;
    if ({client_valid, client_error, lut_req, lut_fault} !== '0) begin
      n_bad++;
      $display("FAIL idle_after_reset: valid=%b err=%b req=%b fault=%b, required 0",
               client_valid, client_error, lut_req, lut_fault);
    end
  endtask

  task automatic test_single();
    do_reset();
    set_client(0, LUT_HANDLE_SIN, 16'h4000);
    push(0, 1'b0, 16'h7FFF);
    client_req[0] = 1'b1;
    tick();
    n_vec++;
    if (lut_req !== 1'b0) begin
      n_bad++;
      $display("FAIL single_req_early: lut_req=%b one cycle after request, required 0", lut_req);
    end
    tick();
    n_vec++;
    if (lut_req !== 1'b1 || lut_arg !== 16'h4000 || lut_handle !== LUT_HANDLE_SIN) begin
      n_bad++;
      $display("FAIL single_issue: req=%b arg=%h handle=%0d, required 1 4000 0", lut_req, lut_arg, lut_handle);
    end
    wait_idle(50, "single");
    n_vec++;
    if (last_pulse_cyc - last_req_cyc !== m_delay + 1) begin
      n_bad++;
      $display("FAIL single_latency: valid %0d cycles after lut_req, required %0d",
               last_pulse_cyc - last_req_cyc, m_delay + 1);
    end
  endtask

  task automatic test_round_robin();
    int gv;
    do_reset();
    gv = gap_viol;
    set_client(1, LUT_HANDLE_TANH, 16'h1111);
    set_client(3, LUT_HANDLE_SIN, 16'h3333);
    push(1, 1'b0, lut_model(LUT_HANDLE_TANH, 16'h1111));
    push(3, 1'b0, lut_model(LUT_HANDLE_SIN, 16'h3333));
    client_req = 4'b1010;
    wait_idle(100, "rr_1_3");
    set_client(0, LUT_HANDLE_SIN, 16'h0A0A);
    set_client(1, LUT_HANDLE_TANH, 16'h1B1B);
    push(0, 1'b0, lut_model(LUT_HANDLE_SIN, 16'h0A0A));
    push(1, 1'b0, lut_model(LUT_HANDLE_TANH, 16'h1B1B));
    client_req = 4'b0011;
    wait_idle(100, "rr_0_1");
    n_vec++;
    if (gap_viol != gv) begin
      n_bad++;
      $display("FAIL rr_gap: %0d lut_req issued <3 cycles after lut_valid, required 0", gap_viol - gv);
    end
  endtask

  task automatic test_bad_handle();
    int rc;
    do_reset();
    rc = req_count;
    set_client(2, HW'(3), 16'h2222);
    set_client(3, LUT_HANDLE_TANH, 16'h3030);
    push(2, 1'b1, '0);
    push(3, 1'b0, lut_model(LUT_HANDLE_TANH, 16'h3030));
    client_req = 4'b1100;
    tick();
    n_vec++;
    if (client_error !== 4'b0100 || lut_req !== 1'b0) begin
      n_bad++;
      $display("FAIL bad_handle_reject: error=%b lut_req=%b, required 0100 0", client_error, lut_req);
    end
    wait_idle(100, "bad_handle");
    n_vec++;
    if (req_count - rc != 1 || lut_handle !== LUT_HANDLE_TANH) begin
      n_bad++;
      $display("FAIL bad_handle_reqs: %0d lut_req, last handle %0d, required 1 and %0d",
               req_count - rc, lut_handle, LUT_HANDLE_TANH);
    end
  endtask

  task automatic test_back_to_back();
    int cnt[NC];
    int gv;
    int n;
    do_reset();
    gv = gap_viol;
    for (int i = 0; i < NC; i++) begin
      cnt[i] = 0;
      set_client(i, HW'(i % 2), DW'(16'h1000 * (i + 1) + i));
    end
    for (int t = 0; t < 20; t++)
      push(t % NC, 1'b0, lut_model(HW'((t % NC) % 2), DW'(16'h1000 * ((t % NC) + 1) + (t % NC))));
    client_req = '1;
    n = 0;
    while ((sb.size() != 0 || client_req != '0) && n < 2000) begin
      tick();
      n++;
      for (int i = 0; i < NC; i++) begin
        if (done_mask[i]) cnt[i]++;
        else if (cnt[i] < 5) client_req[i] = 1'b1;
      end
    end
    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL b2b_drain: %0d results pending, required 0", sb.size());
      sb.delete();
      client_req = '0;
    end
    n_vec++;
    if (gap_viol != gv) begin
      n_bad++;
      $display("FAIL b2b_gap: %0d lut_req issued <3 cycles after lut_valid, required 0", gap_viol - gv);
    end
  endtask

  task automatic test_timeout();
    int r;
    int n;
    int rc;
    do_reset();
    m_hang = 1'b1;
    set_client(1, LUT_HANDLE_TANH, 16'h7777);
    push(1, 1'b1, '0);
    client_req[1] = 1'b1;
    n = 0;
    while (!lut_req && n < 20) begin tick(); n++; end
    r = cyc;
    n_vec++;
    if (!lut_req) begin
      n_bad++;
      $display("FAIL timeout_issue: lut_req=%b, required 1", lut_req);
    end
    wait_idle(200, "timeout");
    n_vec++;
    if (last_pulse_cyc - r !== TO || lut_fault !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout_error: error %0d cycles after lut_req fault=%b, required %0d and 1",
               last_pulse_cyc - r, lut_fault, TO);
    end
    m_hang = 1'b0;
    rc = req_count;
    set_client(3, LUT_HANDLE_SIN, 16'h0001);
    push(3, 1'b1, '0);
    client_req[3] = 1'b1;
    wait_idle(50, "fault_reject");
    n_vec++;
    if (req_count != rc || lut_fault !== 1'b1) begin
      n_bad++;
      $display("FAIL fault_sticky: %0d lut_req, fault=%b, required 0 and 1", req_count - rc, lut_fault);
    end
  endtask

  task automatic test_reset_in_wait();
    int n;
    int c0;
    do_reset();
    set_client(0, LUT_HANDLE_TANH, 16'h5555);
    client_req[0] = 1'b1;
    n = 0;
    while (!lut_req && n < 20) begin tick(); n++; end
    tick(); tick();
    reset = 1'b0;
    client_req = '0;
    c0 = cyc;
    #1;
    n_vec++;
    if ({client_valid, client_error, client_data, lut_req, lut_handle, lut_arg, lut_fault} !== '0) begin
      n_bad++;
      $display("FAIL reset_in_wait: valid=%b err=%b data=%h req=%b h=%h arg=%h fault=%b, required all 0",
               client_valid, client_error, client_data, lut_req, lut_handle, lut_arg, lut_fault);
    end
    repeat (3) tick();
    reset = 1'b1;
    repeat (8) tick();
    n_vec++;
    if (last_pulse_cyc > c0) begin
      n_bad++;
      $display("FAIL reset_no_pulse: pulse at cycle %0d after abort at %0d, required none", last_pulse_cyc, c0);
    end
    set_client(0, LUT_HANDLE_SIN, 16'h0100);
    push(0, 1'b0, lut_model(LUT_HANDLE_SIN, 16'h0100));
    client_req[0] = 1'b1;
    wait_idle(50, "post_reset");
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_bad_handle();
    test_back_to_back();
    test_timeout();
    test_reset_in_wait();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/lut_client_arbiter.md
Name: lut_client_arbiter

Overview:
Initiator side of the LUT lookup interface. It collects lookup requests from up to N_CLIENTS DSP cores and serialises them round-robin onto the single req/valid port of the LUT master. It routes each interpolated result back to the requesting core. It rejects out-of-range handles locally and runs a watchdog so a hung master cannot stall the cores.

Parameters:
DATA_WIDTH, 16, sample/argument width; matches the LUT master data_width.
N_CLIENTS, 4, number of requesting cores (2..8).
N_LUTS, 2, number of valid handles; handles >= N_LUTS are rejected.
TIMEOUT_CYCLES, 256, maximum cycles from lut_req assertion to lut_valid before fault.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-low reset.
client_req  in  N_CLIENTS  per-client level request; held with handle/arg stable until that client's done pulse.
client_handle  in  N_CLIENTS*LUT_HANDLE_WIDTH  packed handles, client i at slice i.
client_arg  in  N_CLIENTS*DATA_WIDTH  packed arguments.
client_valid  out  N_CLIENTS  one-cycle pulse: result for client i is on client_data.
client_error  out  N_CLIENTS  one-cycle pulse: request from client i rejected (bad handle, timeout, or fault).
client_data  out  DATA_WIDTH  shared result bus; valid only alongside a client_valid bit.
lut_req  out  1  request strobe to the LUT master.
lut_handle  out  LUT_HANDLE_WIDTH  handle to the master.
lut_arg  out  DATA_WIDTH  argument to the master.
lut_data  in  DATA_WIDTH  master result.
lut_valid  in  1  master result strobe.
lut_fault  out  1  sticky: master timed out; cleared only by reset.

Behaviour:
- Reset (reset low, asynchronous): all outputs 0; state IDLE; round-robin pointer 0; timeout counter 0; lut_fault 0. Assertion mid-transaction aborts it and emits no pulses.
- States: IDLE, ISSUE, WAIT, RESPOND.
- IDLE:
  - Pick the first client with client_req=1, searching from the pointer upward with wrap.
  - Latch the grant index, handle and arg.
  - Handle >= N_LUTS, or lut_fault=1: pulse client_error[g] next cycle, advance the pointer to g+1, stay IDLE. No lut_req is issued.
  - Otherwise go to ISSUE.
- ISSUE:
  - lut_req=1 for exactly one cycle; lut_handle and lut_arg are driven from the latched values.
  - Clear the timeout counter; go to WAIT.
- WAIT:
  - lut_req=0. lut_handle and lut_arg are held until the transaction ends.
  - Counter increments each cycle.
  - lut_valid=1: capture lut_data and go to RESPOND.
  - Counter reaches TIMEOUT_CYCLES-1 without lut_valid: set lut_fault, pulse client_error[g], go to IDLE.
  - lut_valid in the timeout cycle: valid wins.
- RESPOND:
  - client_data=captured value and client_valid[g]=1 for one cycle.
  - Pointer <= g+1 mod N_CLIENTS; go to IDLE.
- Latency: from client_req sampled in IDLE, lut_req is high 2 cycles later. client_valid goes high 1 cycle after lut_valid.
- The next lut_req is no earlier than 3 cycles after lut_valid. This guarantees the master is back in READY.
- A client dropping client_req while granted does not cancel the transaction. The pulse is still issued and the client ignores it.
- At most one client_valid/client_error bit is set in any cycle; valid and error are never both set.
- Unselected clients wait indefinitely. Round-robin bounds the wait at N_CLIENTS-1 transactions.
- Stray lut_valid outside WAIT is ignored.
- client_data holds its last value between pulses.

Decomposition:
- Shared package/header: LUT_HANDLE_WIDTH, LUT_HANDLE_SIN (0), LUT_HANDLE_TANH (1), arbiter state encodings.
- One natural sub-module: rr_priority_select. It is combinational: request vector plus pointer in, one-hot grant plus index plus any_req out. It is reused by other shared-resource arbiters.

Test Plan:
- Client 0 requests handle 0, arg 0x4000; master model answers 0x7FFF after 5 cycles -> lut_req 2 cycles after request, lut_arg=0x4000, client_valid[0] with client_data=0x7FFF one cycle after lut_valid.
- Clients 1 and 3 request simultaneously, pointer=0 -> client 1 served first, then 3. A following simultaneous 0+1 request serves 0 then 1.
- Client 2 sends handle 3 with N_LUTS=2 -> client_error[2] pulse, lut_req never asserts, other clients unaffected.
- Master model never returns valid -> client_error pulse after TIMEOUT_CYCLES, lut_fault=1; every later request gets client_error with no lut_req.
- All 4 clients hold requests continuously for 20 transactions -> grants cycle 0,1,2,3 repeatedly and each gap between lut_valid and the next lut_req is >= 3 cycles.
- Reset asserted during WAIT -> all outputs 0 immediately, no pulse. After release, a fresh request from client 0 completes normally.
